// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shared single-port memory arbiter for fetch and data ports
module mem_port_arbiter #(
    parameter int unsigned MAX_D_RUN = 4
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    output logic        stall
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [3:0] MAX_RUN = 4'(MAX_D_RUN);

    state_t     state;
    state_t     state_next;
    logic       grant_i;
    logic       grant_d;
    logic [3:0] d_run;

    // Pipeline freeze while any request is outstanding and not yet completed
    assign stall = (if_req & ~if_done) | (d_req & ~d_done);

    // Next-state and grant decision; data wins unless it has starved fetch for MAX_D_RUN grants
    always_comb begin
        state_next = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && (!if_req || d_run != MAX_RUN)) begin
                    grant_d    = 1'b1;
                    state_next = BUSY_D;
                end else if (if_req) begin
                    grant_i    = 1'b1;
                    state_next = BUSY_I;
                end
            end
            BUSY_I: if (m_ack) state_next = RESP;
            BUSY_D: if (m_ack) state_next = RESP;
            RESP:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register, memory-side request registers, read captures and done pulses
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state    <= IDLE;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= 32'd0;
            m_wdata  <= 32'd0;
            if_rdata <= 32'd0;
            d_rdata  <= 32'd0;
            if_done  <= 1'b0;
            d_done   <= 1'b0;
            d_run    <= 4'd0;
        end else begin
            state   <= state_next;
            if_done <= 1'b0;
            d_done  <= 1'b0;
            if (grant_i) begin
                m_req   <= 1'b1;
                m_we    <= 1'b0;
                m_addr  <= if_addr;
                m_wdata <= 32'd0;
                d_run   <= 4'd0;
            end
            if (grant_d) begin
                m_req   <= 1'b1;
                m_we    <= d_we;
                m_addr  <= d_addr;
                m_wdata <= d_wdata;
                // Only count data grants that actually made a fetch wait
                if (!if_req)
                    d_run <= 4'd0;
                else if (d_run != MAX_RUN)
                    d_run <= d_run + 4'd1;
            end
            if (state == BUSY_I && m_ack) begin
                if_rdata <= m_rdata;
                m_req    <= 1'b0;
                if_done  <= 1'b1;
            end
            if (state == BUSY_D && m_ack) begin
                // Stores leave the load-data register untouched
                if (!m_we)
                    d_rdata <= m_rdata;
                m_req  <= 1'b0;
                d_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;
    logic        stall;

    int checks = 0;
    int failures = 0;

    mem_port_arbiter #(.MAX_D_RUN(4)) dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_done  (if_done),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_done   (d_done),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata),
        .m_ack    (m_ack),
        .stall    (stall)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic        rn;
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic        ack;
        logic [31:0] rdata;
        logic        e_mreq;
        logic        e_mwe;
        logic [31:0] e_maddr;
        logic [31:0] e_mwdata;
        logic        e_idone;
        logic        e_ddone;
        logic [31:0] e_irdata;
        logic [31:0] e_drdata;
        logic        e_stall;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    initial begin
        int g;
        int budget;
        logic [31:0] exp_addr;

        Resetn = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; m_ack = 1'b0; m_rdata = '0;

        // rn ireq iaddr dreq dwe daddr dwdata ack rdata | mreq mwe maddr mwdata idone ddone irdata drdata stall
        vecs[0]  = '{0,0,32'h0,0,0,32'h0,32'h0,0,32'h0,        0,0,32'h0,32'h0,0,0,32'h0,32'h0,0};
        vecs[1]  = '{1,0,32'h0,0,0,32'h0,32'h0,1,32'h12345678, 0,0,32'h0,32'h0,0,0,32'h0,32'h0,0};
        vecs[2]  = '{1,1,32'h40,0,0,32'h0,32'h0,0,32'h0,       1,0,32'h40,32'h0,0,0,32'h0,32'h0,1};
        vecs[3]  = '{1,1,32'h40,0,0,32'h0,32'h0,1,32'h8C220004, 0,0,32'h40,32'h0,1,0,32'h8C220004,32'h0,0};
        vecs[4]  = '{1,0,32'h0,0,0,32'h0,32'h0,0,32'h0,        0,0,32'h40,32'h0,0,0,32'h8C220004,32'h0,0};
        vecs[5]  = '{1,0,32'h0,1,1,32'h10,32'hDEADBEEF,0,32'h0, 1,1,32'h10,32'hDEADBEEF,0,0,32'h8C220004,32'h0,1};
        vecs[6]  = '{1,0,32'h0,1,1,32'h99,32'h11111111,0,32'h0, 1,1,32'h10,32'hDEADBEEF,0,0,32'h8C220004,32'h0,1};
        vecs[7]  = '{1,0,32'h0,1,1,32'h99,32'h11111111,0,32'h0, 1,1,32'h10,32'hDEADBEEF,0,0,32'h8C220004,32'h0,1};
        vecs[8]  = '{1,0,32'h0,1,1,32'h99,32'h11111111,0,32'h0, 1,1,32'h10,32'hDEADBEEF,0,0,32'h8C220004,32'h0,1};
        vecs[9]  = '{1,0,32'h0,1,1,32'h99,32'h11111111,1,32'hAAAA5555, 0,1,32'h10,32'hDEADBEEF,0,1,32'h8C220004,32'h0,0};
        vecs[10] = '{1,0,32'h0,0,0,32'h0,32'h0,0,32'h0,        0,1,32'h10,32'hDEADBEEF,0,0,32'h8C220004,32'h0,0};
        vecs[11] = '{1,0,32'h0,1,0,32'h20,32'h0,0,32'h0,       1,0,32'h20,32'h0,0,0,32'h8C220004,32'h0,1};
        vecs[12] = '{1,0,32'h0,1,0,32'h20,32'h0,1,32'hCAFEF00D, 0,0,32'h20,32'h0,0,1,32'h8C220004,32'hCAFEF00D,0};
        vecs[13] = '{1,0,32'h0,0,0,32'h0,32'h0,1,32'h77777777, 0,0,32'h20,32'h0,0,0,32'h8C220004,32'hCAFEF00D,0};
        vecs[14] = '{1,0,32'h0,0,0,32'h0,32'h0,1,32'h12345678, 0,0,32'h20,32'h0,0,0,32'h8C220004,32'hCAFEF00D,0};

        @(negedge Clock);
        for (int i = 0; i < 15; i++) begin
            Resetn = vecs[i].rn; if_req = vecs[i].ireq; if_addr = vecs[i].iaddr;
            d_req = vecs[i].dreq; d_we = vecs[i].dwe; d_addr = vecs[i].daddr;
            d_wdata = vecs[i].dwdata; m_ack = vecs[i].ack; m_rdata = vecs[i].rdata;
            @(posedge Clock);
            @(negedge Clock);
            chk($sformatf("v%0d_m_req", i),    32'(m_req),    32'(vecs[i].e_mreq));
            chk($sformatf("v%0d_m_we", i),     32'(m_we),     32'(vecs[i].e_mwe));
            chk($sformatf("v%0d_m_addr", i),   m_addr,        vecs[i].e_maddr);
            chk($sformatf("v%0d_m_wdata", i),  m_wdata,       vecs[i].e_mwdata);
            chk($sformatf("v%0d_if_done", i),  32'(if_done),  32'(vecs[i].e_idone));
            chk($sformatf("v%0d_d_done", i),   32'(d_done),   32'(vecs[i].e_ddone));
            chk($sformatf("v%0d_if_rdata", i), if_rdata,      vecs[i].e_irdata);
            chk($sformatf("v%0d_d_rdata", i),  d_rdata,       vecs[i].e_drdata);
            chk($sformatf("v%0d_stall", i),    32'(stall),    32'(vecs[i].e_stall));
        end
        m_ack = 1'b0;

        // Contention: both requesters held, instant acks, expect D,D,D,D,I repeating
        if_req = 1'b1; if_addr = 32'h100; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        g = 0;
        budget = 0;
        while (g < 10 && budget < 100) begin
            @(posedge Clock);
            @(negedge Clock);
            budget++;
            chk("contention_stall", 32'(stall), 32'd1);
            if (m_ack) begin
                m_ack = 1'b0;
            end else if (m_req) begin
                exp_addr = (g == 4 || g == 9) ? 32'h100 : 32'h200;
                chk($sformatf("contention_grant%0d", g), m_addr, exp_addr);
                m_ack = 1'b1;
                m_rdata = 32'h1000 + 32'(g);
                g++;
            end
        end
        chk("contention_grant_count", 32'(g), 32'd10);
        @(posedge Clock);
        @(negedge Clock);
        m_ack = 1'b0; if_req = 1'b0; d_req = 1'b0;
        repeat (3) @(negedge Clock);

        // Reset in the middle of a data access; request held high through reset
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30;
        @(posedge Clock);
        @(negedge Clock);
        chk("rst_busy_m_req", 32'(m_req), 32'd1);
        Resetn = 1'b0;
        @(posedge Clock);
        @(negedge Clock);
        chk("rst_m_req", 32'(m_req), 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        @(posedge Clock);
        @(negedge Clock);
        chk("rst_hold_no_grant", 32'(m_req), 32'd0);
        Resetn = 1'b1; d_req = 1'b0; m_ack = 1'b1; m_rdata = 32'h55555555;
        @(posedge Clock);
        @(negedge Clock);
        chk("late_ack_d_done", 32'(d_done), 32'd0);
        chk("late_ack_d_rdata", d_rdata, 32'd0);
        chk("late_ack_m_req", 32'(m_req), 32'd0);
        m_ack = 1'b0; d_req = 1'b1; d_addr = 32'h44;
        @(posedge Clock);
        @(negedge Clock);
        chk("post_rst_idle_grant", 32'(m_req), 32'd1);
        chk("post_rst_grant_addr", m_addr, 32'h44);
        d_req = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
